// File: rtl/aes_pkg.sv
// Shared types and constants for the AES serial subnode: FSM state encoding,
// frame field sizes and header bit positions.
package aes_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        MSG   = 3'd2,
        KEY   = 3'd3,
        START = 3'd4,
        WAIT  = 3'd5,
        SHIFT = 3'd6,
        END   = 3'd7
    } subnode_state_t;

    localparam int HDR_BITS     = 8;
    localparam int BLOCK_BITS   = 128;
    localparam int MODE_BIT     = 7;
    localparam int KEEP_KEY_BIT = 6;

endpackage

// File: rtl/aes_spi_subnode_if.sv
// Serial link between the Master World host and the subnode.
interface aes_spi_subnode_if;

    logic cs;
    logic sdi;
    logic sdo;
    logic sdo_oe;

    modport master (output cs, output sdi, input sdo, input sdo_oe);
    modport slave  (input cs, input sdi, output sdo, output sdo_oe);

endinterface

// File: rtl/aes_spi_subnode_piso.sv
// Loadable 128-bit parallel-in/serial-out register; MSB leaves first.
module subnode_piso
    import aes_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  shift,
    input  logic [BLOCK_BITS-1:0] din,
    output logic                  msb
);

    logic [BLOCK_BITS-1:0] sr_r;

    // Load has priority over shift
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_r <= '0;
        end else if (load) begin
            sr_r <= din;
        end else if (shift) begin
            sr_r <= {sr_r[BLOCK_BITS-2:0], 1'b0};
        end else begin
            sr_r <= sr_r;
        end
    end

    assign msb = sr_r[BLOCK_BITS-1];

endmodule

// File: rtl/aes_spi_subnode.sv
// Serial front end for the AES engine: header/block/key deserialiser, engine
// start/done handshake and result serialiser. Key reuse: SUBNODE_KEY_CACHE_EN.
module aes_spi_subnode
    import aes_pkg::*;
#(
    parameter int NK = 8,
    parameter int NB = 4
) (
    input  logic                 in_clk,
    input  logic                 rst,
    aes_spi_subnode_if.slave     spi,
    output logic [32*NB-1:0]     to_enc_dec_msg,
    output logic [32*NK-1:0]     to_enc_dec_key,
    output logic                 enc_mode,
    output logic                 start,
    input  logic                 done,
    input  logic [32*NB-1:0]     from_enc_dec_msg,
    output logic                 busy,
    output logic                 err
);

    localparam int KEY_BITS = 32 * NK;
    localparam int MSG_BITS = 32 * NB;
    localparam int CNT_W    = $clog2(KEY_BITS + 1);

    subnode_state_t      state_r;
    subnode_state_t      state_nxt_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    cnt_nxt_s;
    logic [HDR_BITS-2:0] hdr_sr_r;
    logic                sdo_oe_r;
    logic                abort_s;
    logic                count_s;
    logic                hdr_en_s;
    logic                hdr_done_s;
    logic                msg_en_s;
    logic                key_en_s;
    logic                piso_load_s;
    logic                piso_shift_s;
    logic                piso_msb_s;
    logic                skip_key_s;

    // State and bit-counter registers
    always_ff @(posedge in_clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next state, counter and datapath strobes; cs high mid-frame aborts
    always_comb begin
        state_nxt_s  = state_r;
        abort_s      = 1'b0;
        count_s      = 1'b0;
        hdr_en_s     = 1'b0;
        hdr_done_s   = 1'b0;
        msg_en_s     = 1'b0;
        key_en_s     = 1'b0;
        piso_load_s  = 1'b0;
        piso_shift_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (!spi.cs) begin
                    state_nxt_s = HDR;
                    hdr_en_s    = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            HDR: begin
                if (spi.cs) begin
                    abort_s     = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    hdr_en_s = 1'b1;
                    count_s  = 1'b1;
                    if (cnt_r == CNT_W'(HDR_BITS - 2)) begin
                        hdr_done_s  = 1'b1;
                        state_nxt_s = MSG;
                    end else begin
                        state_nxt_s = HDR;
                    end
                end
            end
            MSG: begin
                if (spi.cs) begin
                    abort_s     = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    msg_en_s = 1'b1;
                    count_s  = 1'b1;
                    if (cnt_r == CNT_W'(MSG_BITS - 1)) begin
                        state_nxt_s = skip_key_s ? START : KEY;
                    end else begin
                        state_nxt_s = MSG;
                    end
                end
            end
            KEY: begin
                if (spi.cs) begin
                    abort_s     = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    key_en_s = 1'b1;
                    count_s  = 1'b1;
                    if (cnt_r == CNT_W'(KEY_BITS - 1)) begin
                        state_nxt_s = START;
                    end else begin
                        state_nxt_s = KEY;
                    end
                end
            end
            START: begin
                if (spi.cs) begin
                    abort_s     = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            WAIT: begin
                if (spi.cs) begin
                    abort_s     = 1'b1;
                    state_nxt_s = IDLE;
                end else if (done) begin
                    piso_load_s = 1'b1;
                    state_nxt_s = SHIFT;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            SHIFT: begin
                if (spi.cs) begin
                    abort_s     = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    piso_shift_s = 1'b1;
                    count_s      = 1'b1;
                    if (cnt_r == CNT_W'(MSG_BITS - 1)) begin
                        state_nxt_s = END;
                    end else begin
                        state_nxt_s = SHIFT;
                    end
                end
            end
            END: begin
                if (spi.cs) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = END;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
        if (state_nxt_s != state_r) begin
            cnt_nxt_s = '0;
        end else if (count_s) begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Frame registers, sticky error and registered handshake outputs
    always_ff @(posedge in_clk or negedge rst) begin
        if (!rst) begin
            hdr_sr_r       <= '0;
            enc_mode       <= 1'b0;
            to_enc_dec_msg <= '0;
            to_enc_dec_key <= '0;
            err            <= 1'b0;
            start          <= 1'b0;
            busy           <= 1'b0;
            sdo_oe_r       <= 1'b0;
        end else begin
            if (hdr_en_s) begin
                hdr_sr_r <= {hdr_sr_r[HDR_BITS-3:0], spi.sdi};
            end
            // The eighth header bit is still on sdi, so mode sits one below MODE_BIT
            if (hdr_done_s) begin
                enc_mode <= hdr_sr_r[MODE_BIT-1];
            end
            if (msg_en_s) begin
                to_enc_dec_msg <= {to_enc_dec_msg[MSG_BITS-2:0], spi.sdi};
            end
            if (key_en_s) begin
                to_enc_dec_key <= {to_enc_dec_key[KEY_BITS-2:0], spi.sdi};
            end
            if (abort_s) begin
                err <= 1'b1;
            end else if (hdr_done_s) begin
                err <= 1'b0;
            end
            start    <= (state_nxt_s == START);
            busy     <= (state_nxt_s != IDLE);
            sdo_oe_r <= (state_nxt_s == SHIFT);
        end
    end

`ifdef SUBNODE_KEY_CACHE_EN
    logic keep_key_r;
    logic key_valid_r;

    // A partially shifted key invalidates the held one until it completes
    always_ff @(posedge in_clk or negedge rst) begin
        if (!rst) begin
            keep_key_r  <= 1'b0;
            key_valid_r <= 1'b0;
        end else begin
            if (hdr_done_s) begin
                keep_key_r <= hdr_sr_r[KEEP_KEY_BIT-1];
            end
            if (key_en_s && (state_nxt_s == START)) begin
                key_valid_r <= 1'b1;
            end else if (key_en_s) begin
                key_valid_r <= 1'b0;
            end
        end
    end

    assign skip_key_s = keep_key_r & key_valid_r;
`else
    assign skip_key_s = 1'b0;
`endif

    subnode_piso u_piso (
        .clk   (in_clk),
        .rst   (rst),
        .load  (piso_load_s),
        .shift (piso_shift_s),
        .din   (from_enc_dec_msg),
        .msb   (piso_msb_s)
    );

    assign spi.sdo    = piso_msb_s;
    assign spi.sdo_oe = sdo_oe_r;

endmodule
